// File: rtl/commit_unit.sv
// commit_unit: in-order retirement stage for a ROB-based LC-3b core.
// It inspects the ROB head each cycle and retires at most one instruction:
// it writes register results back, releases stores to memory, updates the
// branch history table and flushes the pipeline on mispredicted branches and
// on every JMP.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   rob_empty, rob_valid  head presence / result-ready
//   rob_inst, rob_dest    head opcode and destination register
//   rob_value             head result (resolved next PC for BR/JMP)
//   rob_predict, rob_bht  head predicted-taken bit and branch history
//   rob_orig_pc           head instruction PC
//   rob_head_tag          head ROB index
//   rob_re                pop the ROB head (combinational)
//   rf_we/rf_dest/rf_data/rf_tag   register-file write port (combinational)
//   st_commit_req/st_commit_ack    store release handshake
//   flush, redirect_pc    registered pipeline flush pulse and fetch target
//   bht_we/bht_pc/bht_data         branch predictor update (combinational)
//   retired_cnt, mispred_cnt       wrapping event counters
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | examine head, commit it if present and ready
// ST_WAIT | head is a store, waiting for the store queue to write memory
// FLUSH   | one-cycle flush pulse after a mispredict or JMP
module commit_unit #(
  parameter int data_width = 16,
  parameter int tag_width  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rob_empty,
  input  logic                  rob_valid,
  input  logic [3:0]            rob_inst,
  input  logic [2:0]            rob_dest,
  input  logic [data_width-1:0] rob_value,
  input  logic                  rob_predict,
  input  logic [15:0]           rob_orig_pc,
  input  logic [3:0]            rob_bht,
  input  logic [tag_width-1:0]  rob_head_tag,
  output logic                  rob_re,
  output logic                  rf_we,
  output logic [2:0]            rf_dest,
  output logic [data_width-1:0] rf_data,
  output logic [tag_width-1:0]  rf_tag,
  output logic                  st_commit_req,
  input  logic                  st_commit_ack,
  output logic                  flush,
  output logic [15:0]           redirect_pc,
  output logic                  bht_we,
  output logic [15:0]           bht_pc,
  output logic [3:0]            bht_data,
  output logic [15:0]           retired_cnt,
  output logic [15:0]           mispred_cnt
);

  localparam logic [3:0] OP_BR   = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_STB  = 4'h3;
  localparam logic [3:0] OP_JSR  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_LDR  = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_RTI  = 4'h8;
  localparam logic [3:0] OP_NOT  = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'ha;
  localparam logic [3:0] OP_STI  = 4'hb;
  localparam logic [3:0] OP_JMP  = 4'hc;
  localparam logic [3:0] OP_SHF  = 4'hd;
  localparam logic [3:0] OP_LEA  = 4'he;
  localparam logic [3:0] OP_TRAP = 4'hf;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_WAIT = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  state_t state, next_state;

  logic        commit_ok;
  logic [15:0] resolved_pc;
  logic [15:0] seq_pc;
  logic        taken;
  logic        mispredict;
  logic        re_c, we_c, st_req_c, bht_we_c, enter_flush;
  logic        flush_q;
  logic [15:0] redirect_q;
  logic [15:0] retired_q, mispred_q;

  assign commit_ok   = !rob_empty && rob_valid;
  assign resolved_pc = 16'(rob_value);
  assign seq_pc      = rob_orig_pc + 16'd2;
  // Any target other than the fall-through address counts as taken.
  assign taken       = (resolved_pc != seq_pc);
  assign mispredict  = taken ^ rob_predict;

  always_comb begin
    next_state  = state;
    re_c        = 1'b0;
    we_c        = 1'b0;
    st_req_c    = 1'b0;
    bht_we_c    = 1'b0;
    enter_flush = 1'b0;
    case (state)
      IDLE: begin
        if (commit_ok) begin
          case (rob_inst)
            OP_ADD, OP_AND, OP_NOT, OP_LDB, OP_LDI,
            OP_LDR, OP_LEA, OP_SHF, OP_JSR, OP_TRAP: begin
              re_c = 1'b1;
              we_c = 1'b1;
            end
            OP_ST, OP_STB, OP_STI: begin
              st_req_c = 1'b1;
              if (st_commit_ack) re_c = 1'b1;
              else               next_state = ST_WAIT;
            end
            OP_BR: begin
              re_c     = 1'b1;
              bht_we_c = 1'b1;
              if (mispredict) begin
                enter_flush = 1'b1;
                next_state  = FLUSH;
              end
            end
            OP_JMP: begin
              re_c        = 1'b1;
              enter_flush = 1'b1;
              next_state  = FLUSH;
            end
            default: re_c = 1'b1;  // RTI: retire without side effects
          endcase
        end
      end
      ST_WAIT: begin
        st_req_c = 1'b1;
        if (st_commit_ack) begin
          re_c       = 1'b1;
          next_state = IDLE;
        end
      end
      FLUSH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      flush_q    <= 1'b0;
      redirect_q <= 16'h0000;
      retired_q  <= 16'h0000;
      mispred_q  <= 16'h0000;
    end else begin
      state     <= next_state;
      flush_q   <= enter_flush;
      retired_q <= retired_q + {15'd0, re_c};
      mispred_q <= mispred_q + {15'd0, enter_flush};
      if (enter_flush) redirect_q <= resolved_pc;
    end
  end

  // Mealy strobes are masked while reset is held so a committable head
  // sitting in the ROB cannot leak a write during reset.
  assign rob_re        = re_c     & rst_n;
  assign rf_we         = we_c     & rst_n;
  assign st_commit_req = st_req_c & rst_n;
  assign bht_we        = bht_we_c & rst_n;

  assign rf_dest     = rob_dest;
  assign rf_data     = rob_value;
  assign rf_tag      = rob_head_tag;
  assign bht_pc      = rob_orig_pc;
  assign bht_data    = {rob_bht[2:0], taken};
  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign retired_cnt = retired_q;
  assign mispred_cnt = mispred_q;

endmodule

// File: tb/tb_commit_unit.sv
module tb_commit_unit;
  localparam int DW = 16;
  localparam int TW = 3;

  localparam logic [3:0] BR = 4'h0, ADD = 4'h1, LDB = 4'h2, STB = 4'h3,
                         JSR = 4'h4, AND = 4'h5, LDR = 4'h6, ST = 4'h7,
                         RTI = 4'h8, NOT = 4'h9, LDI = 4'ha, STI = 4'hb,
                         JMP = 4'hc, SHF = 4'hd, LEA = 4'he, TRAP = 4'hf;

  localparam int M_IDLE = 0, M_WAIT = 1, M_FLUSH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rob_empty, rob_valid, rob_predict, st_commit_ack;
  logic [3:0]    rob_inst, rob_bht;
  logic [2:0]    rob_dest;
  logic [DW-1:0] rob_value;
  logic [15:0]   rob_orig_pc;
  logic [TW-1:0] rob_head_tag;

  logic          rob_re, rf_we, st_commit_req, flush, bht_we;
  logic [2:0]    rf_dest;
  logic [DW-1:0] rf_data;
  logic [TW-1:0] rf_tag;
  logic [15:0]   redirect_pc, bht_pc, retired_cnt, mispred_cnt;
  logic [3:0]    bht_data;

  commit_unit #(.data_width(DW), .tag_width(TW)) dut (
    .clk(clk), .rst_n(rst_n), .rob_empty(rob_empty), .rob_valid(rob_valid),
    .rob_inst(rob_inst), .rob_dest(rob_dest), .rob_value(rob_value),
    .rob_predict(rob_predict), .rob_orig_pc(rob_orig_pc), .rob_bht(rob_bht),
    .rob_head_tag(rob_head_tag), .rob_re(rob_re), .rf_we(rf_we),
    .rf_dest(rf_dest), .rf_data(rf_data), .rf_tag(rf_tag),
    .st_commit_req(st_commit_req), .st_commit_ack(st_commit_ack),
    .flush(flush), .redirect_pc(redirect_pc), .bht_we(bht_we),
    .bht_pc(bht_pc), .bht_data(bht_data), .retired_cnt(retired_cnt),
    .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic          re, we, st_req, flush, bht_we;
    logic [2:0]    dest;
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic [15:0]   redir, bpc, ret, mis;
    logic [3:0]    bdata;
  } exp_t;

  exp_t sb_q[$];
  int n_vec = 0;
  int n_err = 0;

  // Reference model: retirement rules applied to the head presented this cycle.
  int          m_mode = M_IDLE;
  logic [15:0] m_ret = 16'h0, m_mis = 16'h0, m_redir = 16'h0;

  task automatic model_step();
    exp_t e;
    logic enter, tk;
    enter = 1'b0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_ret = 16'h0; m_mis = 16'h0; m_redir = 16'h0;
    end
    e.re = 0; e.we = 0; e.st_req = 0; e.flush = 0; e.bht_we = 0;
    e.dest = rob_dest; e.data = rob_value; e.tag = rob_head_tag;
    e.bpc = rob_orig_pc; e.bdata = 4'h0;
    e.ret = m_ret; e.mis = m_mis; e.redir = m_redir;
    if (rst_n) begin
      if (m_mode == M_FLUSH) begin
        e.flush = 1; m_mode = M_IDLE;
      end else if (m_mode == M_WAIT) begin
        e.st_req = 1;
        if (st_commit_ack) begin e.re = 1; m_mode = M_IDLE; end
      end else if (!rob_empty && rob_valid) begin
        if (rob_inst inside {ADD, AND, NOT, LDB, LDI, LDR, LEA, SHF, JSR, TRAP}) begin
          e.re = 1; e.we = 1;
        end else if (rob_inst inside {ST, STB, STI}) begin
          e.st_req = 1;
          if (st_commit_ack) e.re = 1; else m_mode = M_WAIT;
        end else if (rob_inst == BR) begin
          tk = (rob_value != rob_orig_pc + 16'd2);
          e.re = 1; e.bht_we = 1; e.bdata = {rob_bht[2:0], tk};
          if (tk != rob_predict) enter = 1;
        end else if (rob_inst == JMP) begin
          e.re = 1; enter = 1;
        end else begin
          e.re = 1;
        end
      end
      if (enter) begin
        m_mis = m_mis + 16'd1; m_redir = rob_value; m_mode = M_FLUSH;
      end
      if (e.re) m_ret = m_ret + 16'd1;
    end
    sb_q.push_back(e);
  endtask

  task automatic apply(input logic rn, input logic empty, input logic valid,
                       input logic [3:0] inst, input logic [2:0] dest,
                       input logic [15:0] value, input logic pred,
                       input logic [15:0] opc, input logic [3:0] bht,
                       input logic [2:0] tag, input logic ack);
    @(posedge clk);
    #1;
    rst_n = rn; rob_empty = empty; rob_valid = valid; rob_inst = inst;
    rob_dest = dest; rob_value = value; rob_predict = pred; rob_orig_pc = opc;
    rob_bht = bht; rob_head_tag = tag; st_commit_ack = ack;
    model_step();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    if (act !== expv) begin
      n_err++;
      if (n_err <= 30)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_vec++;
        chk("rob_re", 32'(rob_re), 32'(e.re));
        chk("rf_we", 32'(rf_we), 32'(e.we));
        chk("st_commit_req", 32'(st_commit_req), 32'(e.st_req));
        chk("bht_we", 32'(bht_we), 32'(e.bht_we));
        chk("flush", 32'(flush), 32'(e.flush));
        chk("redirect_pc", 32'(redirect_pc), 32'(e.redir));
        chk("retired_cnt", 32'(retired_cnt), 32'(e.ret));
        chk("mispred_cnt", 32'(mispred_cnt), 32'(e.mis));
        if (e.we) begin
          chk("rf_dest", 32'(rf_dest), 32'(e.dest));
          chk("rf_data", 32'(rf_data), 32'(e.data));
          chk("rf_tag", 32'(rf_tag), 32'(e.tag));
        end
        if (e.bht_we) begin
          chk("bht_pc", 32'(bht_pc), 32'(e.bpc));
          chk("bht_data", 32'(bht_data), 32'(e.bdata));
        end
      end
    end
  end

  initial begin : stim
    logic [3:0]  inst;
    logic [15:0] opc, val;
    rst_n = 0; rob_empty = 1; rob_valid = 0; rob_inst = 0; rob_dest = 0;
    rob_value = 0; rob_predict = 0; rob_orig_pc = 0; rob_bht = 0;
    rob_head_tag = 0; st_commit_ack = 0;

    // reset held with a committable head present: nothing may strobe
    repeat (2) apply(0, 0, 1, ADD, 3'd3, 16'h1234, 0, 16'h0, 4'h0, 3'd5, 0);
    // first edge after release commits the ADD
    apply(1, 0, 1, ADD, 3'd3, 16'h1234, 0, 16'h0, 4'h0, 3'd5, 0);
    // store: ack low three cycles, then high
    repeat (3) apply(1, 0, 1, ST, 3'd0, 16'h0, 0, 16'h0, 4'h0, 3'd1, 0);
    apply(1, 0, 1, ST, 3'd0, 16'h0, 0, 16'h0, 4'h0, 3'd1, 1);
    // mispredicted taken branch, then an ADD that must wait out the flush
    apply(1, 0, 1, BR, 3'd0, 16'h3040, 0, 16'h3000, 4'b0101, 3'd2, 0);
    apply(1, 0, 1, ADD, 3'd1, 16'h00aa, 0, 16'h0, 4'h0, 3'd3, 0);
    apply(1, 0, 1, ADD, 3'd1, 16'h00aa, 0, 16'h0, 4'h0, 3'd3, 0);
    // correctly predicted not-taken branch
    apply(1, 0, 1, BR, 3'd0, 16'h3002, 0, 16'h3000, 4'b0101, 3'd4, 0);
    apply(1, 1, 0, ADD, 3'd0, 16'h0, 0, 16'h0, 4'h0, 3'd0, 0);
    // JMP and RTI
    apply(1, 0, 1, JMP, 3'd0, 16'h4000, 1, 16'h3100, 4'h0, 3'd5, 0);
    apply(1, 0, 1, RTI, 3'd0, 16'h0, 0, 16'h0, 4'h0, 3'd6, 0);
    apply(1, 0, 1, RTI, 3'd0, 16'h0, 0, 16'h0, 4'h0, 3'd6, 0);
    // reset in the middle of ST_WAIT
    apply(1, 0, 1, STI, 3'd0, 16'h0, 0, 16'h0, 4'h0, 3'd7, 0);
    apply(1, 0, 1, STI, 3'd0, 16'h0, 0, 16'h0, 4'h0, 3'd7, 0);
    apply(0, 0, 1, STI, 3'd0, 16'h0, 0, 16'h0, 4'h0, 3'd7, 0);
    repeat (2) apply(1, 1, 0, STI, 3'd0, 16'h0, 0, 16'h0, 4'h0, 3'd7, 1);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      inst = 4'($urandom_range(0, 15));
      opc  = 16'($urandom) & 16'hfffe;
      val  = ($urandom_range(0, 1) == 1) ? opc + 16'd2 : 16'($urandom);
      apply(($urandom_range(0, 199) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0), inst, 3'($urandom), val,
            1'($urandom), opc, 4'($urandom), 3'($urandom), 1'($urandom));
    end

    // counter wrap: continuous commits past 0xFFFF
    apply(0, 1, 0, ADD, 3'd0, 16'h0, 0, 16'h0, 4'h0, 3'd0, 0);
    for (int i = 0; i < 65540; i++)
      apply(1, 0, 1, ADD, 3'(i), 16'(i), 0, 16'h0, 4'h0, 3'(i), 0);
    apply(1, 1, 0, ADD, 3'd0, 16'h0, 0, 16'h0, 4'h0, 3'd0, 0);

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
